cp0: RTL and testbench

CP0 -- requirements
Module: cp0

---
 rtl/cp0_pkg.sv | 14 +
 rtl/cp0.sv | 92 +++++++++
 tb/tb_cp0.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 block: register numbers and exception codes.
package cp0_pkg;
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;
endpackage

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRId, exception and interrupt request generation,
// and the eret target.
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID = 32'h2024_0005
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Add,
    input  logic [31:0] CP0In,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] CP0Out,
    output logic [31:0] EPCOut,
    output logic        Req
);
    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [31:0] victim_epc;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    assign int_req    = ie & ~exl & (|(HWInt & im));
    assign exc_req    = ~exl & (ExcCodeIn != 5'd0);
    assign Req        = int_req | exc_req;
    // A delay-slot victim restarts at its branch so the branch is re-executed.
    assign victim_epc = (BDIn ? VPC - 32'd4 : VPC) & 32'hFFFF_FFFC;

    assign sr_word    = {16'h0, im, 8'h0, exl, ie};
    assign cause_word = {bd, 15'h0, ip, 3'h0, exc_code, 2'h0};

    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            ip <= HWInt;
            if (Req) begin
                // The victim is flushed, so any mtc0 or eret it carries is dropped.
                exl      <= 1'b1;
                bd       <= BDIn;
                exc_code <= int_req ? EXC_INT : ExcCodeIn;
                epc      <= victim_epc;
            end else begin
                if (en) begin
                    case (CP0Add)
                        REG_SR: begin
                            im  <= CP0In[15:10];
                            exl <= CP0In[1];
                            ie  <= CP0In[0];
                        end
                        REG_EPC: epc <= CP0In;
                        default: ;
                    endcase
                end
                if (EXLClr) exl <= 1'b0;
            end
        end
    end

    always_comb begin
        CP0Out = 32'h0;
        case (CP0Add)
            REG_SR:    CP0Out = sr_word;
            REG_CAUSE: CP0Out = cause_word;
            REG_EPC:   CP0Out = epc;
            REG_PRID:  CP0Out = PRID;
            default:   CP0Out = 32'h0;
        endcase
    end

    // eret directly behind an mtc0 to EPC must see the new value.
    assign EPCOut = (en && CP0Add == REG_EPC) ? CP0In : epc;
endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0 with hand-computed expectations.
module tb_cp0;
    import cp0_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [4:0]  CP0Add;
    logic [31:0] CP0In;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] CP0Out;
    logic [31:0] EPCOut;
    logic        Req;

    int checks = 0;
    int errors = 0;

    cp0 #(.PRID(32'h2024_0005)) dut (
        .clk(clk), .reset(reset), .en(en), .CP0Add(CP0Add), .CP0In(CP0In),
        .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
        .EXLClr(EXLClr), .CP0Out(CP0Out), .EPCOut(EPCOut), .Req(Req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] addr, input string tag, input logic [31:0] exp);
        CP0Add = addr;
        #1;
        chk(tag, CP0Out, exp);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; CP0Add = 5'd0; CP0In = 32'h0; VPC = 32'h0;
        BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
        tick();
        reset = 1'b0;
        rd(REG_SR,    "rst_sr",    32'h0);
        rd(REG_CAUSE, "rst_cause", 32'h0);
        rd(REG_EPC,   "rst_epc",   32'h0);
        rd(REG_PRID,  "prid",      32'h2024_0005);
        rd(5'd3,      "unmapped",  32'h0);
        chk("rst_epcout", EPCOut, 32'h0);
        chk("rst_req", {31'h0, Req}, 32'h0);

        // Enable all interrupt lines, then raise HWInt[2]
        en = 1'b1; CP0Add = REG_SR; CP0In = 32'h0000_FC01;
        tick();
        en = 1'b0;
        rd(REG_SR, "sr_write", 32'h0000_FC01);
        HWInt = 6'b000100; VPC = 32'h3010; BDIn = 1'b0;
        #1;
        chk("int_req", {31'h0, Req}, 32'h1);
        tick();
        HWInt = 6'd0;
        rd(REG_EPC,   "int_epc",   32'h0000_3010);
        rd(REG_SR,    "int_sr",    32'h0000_FC03);
        rd(REG_CAUSE, "int_cause", 32'h0000_1000);
        chk("int_req_masked", {31'h0, Req}, 32'h0);

        // EXL masks both interrupts and exceptions
        HWInt = 6'h3F; ExcCodeIn = EXC_OV; VPC = 32'h3050;
        #1;
        chk("exl_mask_req", {31'h0, Req}, 32'h0);
        tick();
        rd(REG_EPC,   "exl_epc_hold",  32'h0000_3010);
        rd(REG_CAUSE, "exl_cause_ip",  32'h0000_FC00);
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        rd(REG_SR, "eret_sr", 32'h0000_FC01);
        chk("eret_req", {31'h0, Req}, 32'h1);
        HWInt = 6'd0; ExcCodeIn = 5'd0;
        #1;
        chk("idle_req", {31'h0, Req}, 32'h0);

        // Syscall in a delay slot
        ExcCodeIn = EXC_SYSCALL; VPC = 32'h3024; BDIn = 1'b1;
        #1;
        chk("sys_req", {31'h0, Req}, 32'h1);
        tick();
        ExcCodeIn = 5'd0; BDIn = 1'b0;
        rd(REG_EPC,   "sys_epc",   32'h0000_3020);
        rd(REG_CAUSE, "sys_cause", 32'h8000_0020);
        rd(REG_SR,    "sys_sr",    32'h0000_FC03);

        // mtc0 EPC: forwarded to EPCOut now, visible on CP0Out next cycle
        en = 1'b1; CP0Add = REG_EPC; CP0In = 32'h3400;
        #1;
        chk("epc_fwd", EPCOut, 32'h0000_3400);
        chk("epc_no_rdfwd", CP0Out, 32'h0000_3020);
        tick();
        en = 1'b0;
        rd(REG_EPC, "epc_written", 32'h0000_3400);
        chk("epcout_reg", EPCOut, 32'h0000_3400);
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        rd(REG_SR, "eret2_sr", 32'h0000_FC01);

        // Exception on the same edge as mtc0 SR: the write is dropped
        ExcCodeIn = EXC_OV; VPC = 32'h3100; en = 1'b1; CP0Add = REG_SR; CP0In = 32'h0;
        #1;
        chk("ov_req", {31'h0, Req}, 32'h1);
        tick();
        en = 1'b0; ExcCodeIn = 5'd0;
        rd(REG_SR,    "ov_sr_kept", 32'h0000_FC03);
        rd(REG_CAUSE, "ov_cause",   32'h0000_0030);
        rd(REG_EPC,   "ov_epc",     32'h0000_3100);
        EXLClr = 1'b1;
        tick();

        // Exception and eret on one edge: exception wins, EXL stays set
        ExcCodeIn = EXC_ADEL; VPC = 32'h3204; EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0; ExcCodeIn = 5'd0;
        rd(REG_SR,    "adel_sr",    32'h0000_FC03);
        rd(REG_CAUSE, "adel_cause", 32'h0000_0010);
        rd(REG_EPC,   "adel_epc",   32'h0000_3204);
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;

        // Delay-slot victim at address 0 wraps
        ExcCodeIn = EXC_ADES; VPC = 32'h0; BDIn = 1'b1;
        tick();
        ExcCodeIn = 5'd0; BDIn = 1'b0;
        rd(REG_EPC,   "wrap_epc",   32'hFFFF_FFFC);
        rd(REG_CAUSE, "wrap_cause", 32'h8000_0014);

        // Cause is read-only
        en = 1'b1; CP0Add = REG_CAUSE; CP0In = 32'hFFFF_FFFF;
        tick();
        en = 1'b0;
        rd(REG_CAUSE, "cause_ro", 32'h8000_0014);
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;

        // Interrupt beats a simultaneous exception; unaligned VPC is masked
        HWInt = 6'b000001; ExcCodeIn = EXC_RI; VPC = 32'h3203;
        tick();
        ExcCodeIn = 5'd0;
        rd(REG_CAUSE, "prio_cause", 32'h0000_0400);
        rd(REG_EPC,   "prio_epc",   32'h0000_3200);

        // Reset while EXL=1 and an interrupt line is active
        HWInt = 6'h3F; reset = 1'b1; en = 1'b1; CP0Add = REG_SR; CP0In = 32'h0000_FC01; EXLClr = 1'b1;
        tick();
        reset = 1'b0; en = 1'b0; EXLClr = 1'b0;
        rd(REG_SR, "rst2_sr", 32'h0);
        CP0Add = REG_CAUSE;
        #1;
        chk("rst2_cause", CP0Out & 32'hFFFF_03FF, 32'h0);
        rd(REG_EPC, "rst2_epc", 32'h0);
        chk("rst2_epcout", EPCOut, 32'h0);
        chk("rst2_req", {31'h0, Req}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
